// File: rtl/hook_motion_ctrl.sv
// Hook swing/extend/retract motion controller with a one-outstanding draw handshake.
// Motion steps only on accepted frame ticks, so degree/length hold steady while a draw is in flight.
module hook_motion_ctrl #(
  parameter int unsigned DEG_MIN         = 20,
  parameter int unsigned DEG_MAX         = 140,
  parameter int unsigned DEG_INIT        = 80,
  parameter int unsigned DEG_STEP        = 2,
  parameter int unsigned LEN_MIN         = 20,
  parameter int unsigned LEN_MAX         = 200,
  parameter int unsigned LEN_STEP        = 4,
  parameter int unsigned LEN_STEP_LOADED = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic       hit,
  input  logic       draw_done,
  output logic [8:0] degree,
  output logic [9:0] length,
  output logic       draw_enable,
  output logic       busy,
  output logic       grabbed,
  output logic       catch,
  output logic [7:0] overrun
);

  typedef enum logic [1:0] {M_SWING, M_EXTEND, M_RETRACT} mstate_t;
  typedef enum logic [1:0] {H_IDLE, H_REQ, H_WAIT} hstate_t;

  localparam logic [9:0]  D_MIN      = 10'(DEG_MIN);
  localparam logic [9:0]  D_MAX      = 10'(DEG_MAX);
  localparam logic [9:0]  D_STEP     = 10'(DEG_STEP);
  localparam logic [9:0]  D_LOW_EDGE = 10'(DEG_MIN + DEG_STEP);
  localparam logic [10:0] L_MIN      = 11'(LEN_MIN);
  localparam logic [10:0] L_MAX      = 11'(LEN_MAX);
  localparam logic [10:0] L_STEP     = 11'(LEN_STEP);
  localparam logic [10:0] L_STEP_LD  = 11'(LEN_STEP_LOADED);

  mstate_t     mstate_q, mstate_d;
  hstate_t     hstate_q, hstate_d;
  logic [8:0]  degree_q, degree_d;
  logic        dir_up_q, dir_up_d;
  logic [9:0]  length_q, length_d;
  logic        grabbed_q, grabbed_d;
  logic        catch_q, catch_d;
  logic [7:0]  overrun_q, overrun_d;
  logic        pending_q, pending_d;
  logic        fire_prev_q, fire_prev_d;
  logic        draw_enable_q, draw_enable_d;
  logic        busy_q, busy_d;

  logic        update;
  logic        fire_rise;
  logic [9:0]  deg_up;
  logic [10:0] len_up;
  logic [10:0] ret_step;

  always_comb begin
    mstate_d    = mstate_q;
    hstate_d    = hstate_q;
    degree_d    = degree_q;
    dir_up_d    = dir_up_q;
    length_d    = length_q;
    grabbed_d   = grabbed_q;
    catch_d     = 1'b0;
    overrun_d   = overrun_q;
    pending_d   = pending_q;
    fire_prev_d = fire;

    fire_rise = fire & ~fire_prev_q;
    update    = frame_tick && (hstate_q == H_IDLE);
    deg_up    = {1'b0, degree_q} + D_STEP;
    len_up    = {1'b0, length_q} + L_STEP;
    ret_step  = grabbed_q ? L_STEP_LD : L_STEP;

    case (hstate_q)
      H_IDLE:  if (frame_tick) hstate_d = H_REQ;
      H_REQ:   hstate_d = H_WAIT;
      H_WAIT:  if (draw_done) hstate_d = H_IDLE;
      default: hstate_d = H_IDLE;
    endcase

    if (frame_tick && !update && overrun_q != 8'hFF)
      overrun_d = overrun_q + 8'd1;

    // A fire edge on the same cycle as an update survives for the following update.
    if (update)    pending_d = 1'b0;
    if (fire_rise) pending_d = 1'b1;

    if (hit && mstate_q == M_EXTEND) begin
      grabbed_d = 1'b1;
      mstate_d  = M_RETRACT;
    end else if (update) begin
      case (mstate_q)
        M_SWING: begin
          if (pending_q) begin
            mstate_d = M_EXTEND;
          end else if (dir_up_q) begin
            if (deg_up >= D_MAX) begin
              degree_d = D_MAX[8:0];
              dir_up_d = 1'b0;
            end else begin
              degree_d = deg_up[8:0];
            end
          end else if ({1'b0, degree_q} <= D_LOW_EDGE) begin
            degree_d = D_MIN[8:0];
            dir_up_d = 1'b1;
          end else begin
            degree_d = degree_q - D_STEP[8:0];
          end
        end
        M_EXTEND: begin
          if (len_up >= L_MAX) begin
            length_d = L_MAX[9:0];
            mstate_d = M_RETRACT;
          end else begin
            length_d = len_up[9:0];
          end
        end
        M_RETRACT: begin
          if ({1'b0, length_q} <= L_MIN + ret_step) begin
            length_d  = L_MIN[9:0];
            mstate_d  = M_SWING;
            grabbed_d = 1'b0;
            catch_d   = grabbed_q;
          end else begin
            length_d = length_q - ret_step[9:0];
          end
        end
        default: mstate_d = M_SWING;
      endcase
    end

    draw_enable_d = (hstate_d == H_REQ);
    busy_d        = (hstate_d != H_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mstate_q      <= M_SWING;
      hstate_q      <= H_IDLE;
      degree_q      <= 9'(DEG_INIT);
      dir_up_q      <= 1'b1;
      length_q      <= L_MIN[9:0];
      grabbed_q     <= 1'b0;
      catch_q       <= 1'b0;
      overrun_q     <= 8'd0;
      pending_q     <= 1'b0;
      fire_prev_q   <= 1'b0;
      draw_enable_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mstate_q      <= mstate_d;
      hstate_q      <= hstate_d;
      degree_q      <= degree_d;
      dir_up_q      <= dir_up_d;
      length_q      <= length_d;
      grabbed_q     <= grabbed_d;
      catch_q       <= catch_d;
      overrun_q     <= overrun_d;
      pending_q     <= pending_d;
      fire_prev_q   <= fire_prev_d;
      draw_enable_q <= draw_enable_d;
      busy_q        <= busy_d;
    end
  end

  assign degree      = degree_q;
  assign length      = length_q;
  assign draw_enable = draw_enable_q;
  assign busy        = busy_q;
  assign grabbed     = grabbed_q;
  assign catch       = catch_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Scoreboard bench for hook_motion_ctrl: each accepted tick pushes the expected draw snapshot,
// a monitor pops and compares on every draw_enable pulse.
module tb_hook_motion_ctrl;

  logic       clock = 1'b0;
  logic       resetn, frame_tick, fire, hit, draw_done;
  logic [8:0] degree;
  logic [9:0] length;
  logic       draw_enable, busy, grabbed, catch;
  logic [7:0] overrun;

  hook_motion_ctrl dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .fire(fire),
    .hit(hit), .draw_done(draw_done), .degree(degree), .length(length),
    .draw_enable(draw_enable), .busy(busy), .grabbed(grabbed), .catch(catch),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {int deg; int len; int grab; int cat; int ovr;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int catch_seen = 0;

  // Reference model: mode 0 swing, 1 extend, 2 retract; dir is +1/-1.
  int m_mode, m_deg, m_dir, m_len, m_grab, m_pend, m_busy, m_ovr, m_cat;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_deg = 80; m_dir = 1; m_len = 20; m_grab = 0;
    m_pend = 0; m_busy = 0; m_ovr = 0; m_cat = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int nv;
    m_cat = 0;
    if (m_mode == 0) begin
      if (m_pend != 0) m_mode = 1;
      else begin
        nv = m_deg + m_dir * 2;
        if (nv >= 140)     begin m_deg = 140; m_dir = -1; end
        else if (nv <= 20) begin m_deg = 20;  m_dir = 1;  end
        else m_deg = nv;
      end
    end else if (m_mode == 1) begin
      nv = m_len + 4;
      if (nv >= 200) begin m_len = 200; m_mode = 2; end
      else m_len = nv;
    end else begin
      nv = m_len - ((m_grab != 0) ? 1 : 4);
      if (nv <= 20) begin
        m_len = 20; m_mode = 0; m_cat = m_grab; m_grab = 0;
      end else m_len = nv;
    end
    m_pend = 0;
  endtask

  task automatic tick_op(input bit answer, input bit with_hit);
    exp_t e;
    bit hit_taken;
    hit_taken = 0;
    @(negedge clock);
    frame_tick = 1'b1;
    hit = with_hit;
    if (with_hit && m_mode == 1) begin
      m_grab = 1; m_mode = 2; hit_taken = 1;
    end
    if (m_busy == 0) begin
      m_busy = 1;
      if (hit_taken) begin m_cat = 0; m_pend = 0; end
      else model_step();
      e.deg = m_deg; e.len = m_len; e.grab = m_grab; e.cat = m_cat; e.ovr = m_ovr;
      exp_q.push_back(e);
    end else if (m_ovr < 255) begin
      m_ovr++;
    end
    @(negedge clock);
    frame_tick = 1'b0;
    hit = 1'b0;
    @(negedge clock);
    if (answer) begin draw_done = 1'b1; m_busy = 0; end
    @(negedge clock);
    draw_done = 1'b0;
  endtask

  task automatic hit_op();
    @(negedge clock);
    hit = 1'b1;
    if (m_mode == 1) begin m_grab = 1; m_mode = 2; end
    @(negedge clock);
    hit = 1'b0;
  endtask

  task automatic done_op();
    @(negedge clock);
    draw_done = 1'b1;
    m_busy = 0;
    @(negedge clock);
    draw_done = 1'b0;
  endtask

  task automatic fire_op(input int n);
    @(negedge clock);
    fire = 1'b1;
    m_pend = 1;
    repeat (n) @(negedge clock);
    fire = 1'b0;
  endtask

  task automatic reset_op();
    @(negedge clock);
    resetn = 1'b0;
    frame_tick = 1'b0; fire = 1'b0; hit = 1'b0; draw_done = 1'b0;
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " degree"}, int'(degree), 80);
    chk({tag, " length"}, int'(length), 20);
    chk({tag, " draw_enable"}, int'(draw_enable), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " grabbed"}, int'(grabbed), 0);
    chk({tag, " catch"}, int'(catch), 0);
    chk({tag, " overrun"}, int'(overrun), 0);
  endtask

  // Monitor: every draw request must match the next expected snapshot.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (resetn) begin
      if (draw_enable) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL draw_enable: got unexpected pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("draw degree", int'(degree), e.deg);
          chk("draw length", int'(length), e.len);
          chk("draw grabbed", int'(grabbed), e.grab);
          chk("draw catch", int'(catch), e.cat);
          chk("draw overrun", int'(overrun), e.ovr);
          chk("draw busy", int'(busy), 1);
          if (catch) catch_seen++;
        end
      end else if (catch) begin
        checks++; errors++;
        $display("FAIL catch: got pulse without draw request, expected none");
      end
    end
  end

  initial begin
    int held_deg, c0, op;
    resetn = 1'b0; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0; draw_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    chk_reset_outputs("reset");

    // Swing up to the upper bound and bounce back.
    repeat (31) tick_op(1, 0);
    chk("swing bounce degree", int'(degree), 138);

    // Fire, full extension, empty retract home.
    fire_op(1);
    tick_op(1, 0);
    chk("extend start length", int'(length), 20);
    chk("extend start degree", int'(degree), 138);
    repeat (45) tick_op(1, 0);
    chk("full extension length", int'(length), 200);
    repeat (45) tick_op(1, 0);
    chk("empty retract length", int'(length), 20);

    // Grab at length 60 with hit coincident with a tick, then loaded retract.
    fire_op(2);
    tick_op(1, 0);
    repeat (10) tick_op(1, 0);
    chk("pre-hit length", int'(length), 60);
    tick_op(1, 1);
    chk("hit grabbed", int'(grabbed), 1);
    chk("hit length", int'(length), 60);
    c0 = catch_seen;
    repeat (40) tick_op(1, 0);
    chk("loaded home length", int'(length), 20);
    chk("loaded home grabbed", int'(grabbed), 0);
    chk("catch pulses", catch_seen - c0, 1);

    // Overrun saturation while a request is outstanding.
    tick_op(0, 0);
    held_deg = int'(degree);
    repeat (300) tick_op(0, 0);
    chk("overrun saturated", int'(overrun), 255);
    chk("degree held while dropping", int'(degree), held_deg);
    done_op();
    tick_op(1, 0);

    // Reset mid-handshake at length 100.
    fire_op(1);
    tick_op(1, 0);
    repeat (19) tick_op(1, 0);
    tick_op(0, 0);
    chk("wait length", int'(length), 100);
    chk("wait busy", int'(busy), 1);
    reset_op();
    chk_reset_outputs("mid-handshake reset");
    done_op();
    chk("stray draw_done busy", int'(busy), 0);
    tick_op(1, 0);
    chk("post-reset degree", int'(degree), 82);

    // Fire held across three ticks enters EXTEND exactly once.
    @(negedge clock);
    fire = 1'b1;
    m_pend = 1;
    repeat (3) tick_op(1, 0);
    @(negedge clock);
    fire = 1'b0;
    chk("held fire length", int'(length), 28);
    tick_op(1, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      op = $urandom_range(0, 99);
      if (op < 50)      tick_op(1, 0);
      else if (op < 58) tick_op(0, 0);
      else if (op < 68) done_op();
      else if (op < 76) fire_op($urandom_range(1, 3));
      else if (op < 84) hit_op();
      else if (op < 92) tick_op($urandom_range(0, 1) == 1, 1);
      else repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    repeat (4) @(negedge clock);
    chk("scoreboard drained", exp_q.size(), 0);
    chk("final degree", int'(degree), m_deg);
    chk("final length", int'(length), m_len);
    chk("final grabbed", int'(grabbed), m_grab);
    chk("final overrun", int'(overrun), m_ovr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hook_motion_ctrl.md
HOOK_MOTION_CTRL -- requirements
Module: hook_motion_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEG_MIN 20, lower swing bound.
REQ-002 DEG_MAX 140, upper swing bound.
REQ-003 DEG_INIT 80, reset angle.
REQ-004 DEG_STEP 2, swing increment per update.
REQ-005 LEN_MIN 20, rest rope length.
REQ-006 LEN_MAX 200, full extension.
REQ-007 LEN_STEP 4, extend and empty-retract step.
REQ-008 LEN_STEP_LOADED 1, retract step while grabbed.
REQ-009 Ports SHALL be (name, direction, width, meaning): clock input 1, rising-edge clock.
REQ-010 resetn input 1, synchronous, active-low reset.
REQ-011 frame_tick input 1, one-cycle motion-update request.
REQ-012 fire input 1, player button, level, synchronous to clock.
REQ-013 hit input 1, one-cycle collision pulse.
REQ-014 draw_done input 1, one-cycle completion pulse from draw stage.
REQ-015 degree output 9, hook angle passed to draw stage.
REQ-016 length output 10, rope length passed to draw stage.
REQ-017 draw_enable output 1, one-cycle draw request.
REQ-018 busy output 1, draw request outstanding.
REQ-019 grabbed output 1, object attached.
REQ-020 catch output 1, one-cycle pulse when loaded hook returns home.
REQ-021 overrun output 8, count of dropped frame_ticks, saturating.

Function
REQ-022 Motion FSM SHALL have states SWING, EXTEND, RETRACT; handshake FSM SHALL have states IDLE, REQ, WAIT.
REQ-023 A frame_tick seen in IDLE SHALL be an update: motion step applied at that edge, handshake to REQ.
REQ-024 REQ SHALL drive draw_enable=1 for exactly one cycle, then go to WAIT; busy=1 in REQ and WAIT.
REQ-025 WAIT SHALL return to IDLE on draw_done; draw_done outside WAIT SHALL be ignored.
REQ-026 degree and length SHALL change only on update edges, so both stay stable for the whole REQ/WAIT interval.
REQ-027 A frame_tick in REQ or WAIT SHALL be dropped (no motion step), and overrun SHALL increment, saturating at 255.
REQ-028 Rising edge of fire SHALL set a pending flag in any state; pending SHALL clear on the next update.
REQ-029 SWING update with pending=0: degree steps by DEG_STEP in current direction; if the result reaches or crosses DEG_MAX/DEG_MIN, degree clamps to that bound and direction reverses.
REQ-030 SWING update with pending=1: state goes to EXTEND; degree and length remain unchanged.
REQ-031 Pending set while in EXTEND or RETRACT SHALL be discarded at the next update without effect.
REQ-032 EXTEND update: length += LEN_STEP; if length+LEN_STEP >= LEN_MAX, length = LEN_MAX and state goes to RETRACT.
REQ-033 hit in EXTEND SHALL set grabbed=1 and go to RETRACT on that edge without changing length; hit in other states SHALL be ignored.
REQ-034 hit coincident with frame_tick in EXTEND: hit wins, so there is no length increment; the tick still issues a draw request.
REQ-035 RETRACT update: step s = grabbed ? LEN_STEP_LOADED : LEN_STEP; if length <= LEN_MIN+s, length = LEN_MIN, state goes to SWING, grabbed clears, and catch pulses one cycle if grabbed was 1; else length -= s.
REQ-036 The degree direction flag SHALL be preserved through EXTEND/RETRACT, and swinging SHALL resume from the held angle.
REQ-037 Arithmetic SHALL be unsigned, with comparisons made before subtraction; length never leaves [LEN_MIN, LEN_MAX] and degree never leaves [DEG_MIN, DEG_MAX].

Reset
REQ-038 resetn=0 at an edge SHALL force: degree=DEG_INIT, direction increasing, length=LEN_MIN, SWING, IDLE, draw_enable=0, busy=0, grabbed=0, catch=0, overrun=0, pending=0.
REQ-039 Reset mid-handshake SHALL abandon the request; a draw_done arriving afterwards SHALL be ignored.

Verification
REQ-040 Reset, then 31 ticks each answered by draw_done -> degree 80,82..140, then 138; one draw_enable pulse per tick.
REQ-041 fire rises, then tick -> state EXTEND, degree held, length 20; next 45 ticks -> length reaches 200, then state RETRACT.
REQ-042 In EXTEND at length 60, hit coincides with tick -> grabbed=1, length 60; 40 ticks later -> length 20, catch pulses once, SWING.
REQ-043 Tick, no draw_done, then 300 further ticks -> overrun=255, degree unchanged; draw_done then tick -> normal update resumes.
REQ-044 resetn low during WAIT at length 100 -> all outputs at reset values next cycle; stray draw_done ignored.
REQ-045 fire held high across three ticks in SWING -> exactly one transition to EXTEND.
